// File: rtl/dtc_feature_binarizer.sv
// Thresholds each raw sample of a frame against its per-feature threshold and
// packs the bits into one feature vector. Malformed frames are dropped and flagged.
module dtc_feature_binarizer #(
    parameter int N_FEAT = 11,
    parameter int W      = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W-1:0]      s_data,
    input  logic              s_last,
    input  logic              thr_we,
    input  logic [3:0]        thr_idx,
    input  logic [W-1:0]      thr_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_FEAT-1:0] m_feat,
    output logic              err_short,
    output logic              err_long,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int IDX_W = $clog2(N_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [W-1:0]     THR_RST  = W'(1) << (W - 1);

    typedef enum logic {
        FILL    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [N_FEAT-1:0]  asm_q;
    logic [W-1:0]       thr_q [N_FEAT];
    logic               m_valid_q;
    logic [N_FEAT-1:0]  m_feat_q;
    logic               err_short_q;
    logic               err_long_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    logic               beat;
    logic               cmp_bit;
    logic               at_last;
    logic               thr_wr_ok;
    logic [N_FEAT-1:0]  feat_d;

    // Valid/ready: a beat transfers on any edge where s_valid && s_ready, and the
    // output vector transfers on m_valid && m_ready. s_ready never looks at s_valid;
    // it only stalls a completing beat while a held vector cannot leave.
    assign at_last   = (state_q == FILL) && (idx_q == LAST_IDX);
    assign s_ready   = !(at_last && m_valid_q && !m_ready);
    assign beat      = s_valid && s_ready;
    assign thr_wr_ok = thr_we && (int'(thr_idx) < N_FEAT);

    always_comb begin
        cmp_bit = (s_data >= thr_q[idx_q]);
        feat_d  = asm_q;
        feat_d[idx_q] = cmp_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            asm_q       <= '0;
            m_valid_q   <= 1'b0;
            m_feat_q    <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < N_FEAT; i++) begin
                thr_q[i] <= THR_RST;
            end
        end else begin
            // The compare above reads the pre-edge threshold, so a same-index
            // write in this cycle only affects later beats.
            if (thr_wr_ok) begin
                thr_q[thr_idx] <= thr_data;
            end
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (beat) begin
                case (state_q)
                    FILL: begin
                        asm_q <= feat_d;
                        if (at_last) begin
                            idx_q <= '0;
                            if (s_last) begin
                                m_feat_q    <= feat_d;
                                m_valid_q   <= 1'b1;
                                frame_cnt_q <= frame_cnt_q + 1'b1;
                            end else begin
                                err_long_q <= 1'b1;
                                state_q    <= DISCARD;
                            end
                        end else if (s_last) begin
                            err_short_q <= 1'b1;
                            idx_q       <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    DISCARD: begin
                        if (s_last) begin
                            state_q <= FILL;
                            idx_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= FILL;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_feat    = m_feat_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dtc_feature_binarizer.sv
// Bench for dtc_feature_binarizer: table-driven frames, hand-written stall,
// error and reset sequences, and a randomised phase, all scored through exp_q.
module tb_dtc_feature_binarizer;

    localparam int N_FEAT = 11;
    localparam int W      = 8;
    localparam int CNT_W  = 16;
    localparam int FW     = N_FEAT * W;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [W-1:0]      s_data;
    logic              s_last;
    logic              thr_we;
    logic [3:0]        thr_idx;
    logic [W-1:0]      thr_data;
    logic              m_valid;
    logic              m_ready;
    logic [N_FEAT-1:0] m_feat;
    logic              err_short;
    logic              err_long;
    logic [CNT_W-1:0]  frame_cnt;

    dtc_feature_binarizer #(.N_FEAT(N_FEAT), .W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .thr_we(thr_we), .thr_idx(thr_idx), .thr_data(thr_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_feat(m_feat),
        .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [N_FEAT-1:0] exp_q[$];
    logic [W-1:0]      m_thr [N_FEAT];
    logic [CNT_W-1:0]  exp_cnt;
    int n_vec  = 0;
    int n_fail = 0;
    int n_short = 0;
    int n_long  = 0;

    typedef struct {
        logic [FW-1:0]     smp;
        logic [N_FEAT-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Output monitor: a vector transfers on the next edge when m_valid && m_ready here.
    always @(negedge clk) begin
        if (err_short === 1'b1) n_short++;
        if (err_long === 1'b1)  n_long++;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_vec: got 0x%0h, expected none", m_feat);
            end else begin
                check("m_feat", 32'(m_feat), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- model helpers ----------------
    function automatic logic [N_FEAT-1:0] model_feat(input logic [FW-1:0] smp);
        logic [N_FEAT-1:0] f;
        for (int i = 0; i < N_FEAT; i++) f[i] = (smp[i*W +: W] >= m_thr[i]);
        return f;
    endfunction

    task automatic push_exp(input logic [N_FEAT-1:0] e);
        exp_q.push_back(e);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_FEAT; i++) m_thr[i] = 8'h80;
        exp_q.delete();
        exp_cnt = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] smp, input logic [N_FEAT-1:0] e);
        for (int i = 0; i < N_FEAT; i++) begin
            if (i == N_FEAT - 1) push_exp(e);
            send_beat(smp[i*W +: W], i == N_FEAT - 1);
        end
    endtask

    task automatic write_thr(input logic [3:0] idx, input logic [W-1:0] d);
        thr_we = 1'b1;
        thr_idx = idx;
        thr_data = d;
        @(posedge clk);
        #1;
        thr_we = 1'b0;
        if (int'(idx) < N_FEAT) m_thr[idx] = d;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            t++;
            @(posedge clk);
        end
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    vec_t tbl [5];
    logic [FW-1:0] smp;
    logic [FW-1:0] smp_b;
    logic [N_FEAT-1:0] fa;
    int sh0, lg0;
    bit rand_done;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        thr_we = 1'b0; thr_idx = '0; thr_data = '0; m_ready = 1'b1;
        model_reset();

        // Table for thresholds thr[i] = 0x10*i.
        tbl[0].smp = {8'hFF, 8'h90, 8'h90, 8'h60, 8'h70, 8'h60, 8'h30, 8'h40, 8'h20, 8'h20, 8'h00};
        tbl[0].exp = 11'h76F;
        tbl[1].smp = {N_FEAT{8'hFF}};
        tbl[1].exp = 11'h7FF;
        tbl[2].smp = {N_FEAT{8'h00}};
        tbl[2].exp = 11'h001;
        tbl[3].smp = {8'h9F, 8'h8F, 8'h7F, 8'h6F, 8'h5F, 8'h4F, 8'h3F, 8'h2F, 8'h1F, 8'h0F, 8'h00};
        tbl[3].exp = 11'h001;
        tbl[4].smp = {8'hA0, 8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
        tbl[4].exp = 11'h7FF;

        #12;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_feat", 32'(m_feat), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err", 32'({err_short, err_long}), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // Default thresholds, samples 0x00..0x0A -> all zero, single-cycle valid.
        for (int i = 0; i < N_FEAT; i++) smp[i*W +: W] = 8'(i);
        send_frame(smp, 11'h000);
        check("latency_m_valid", 32'(m_valid), 32'd1);
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);
        @(posedge clk);
        #1;
        check("m_valid_one_cycle", 32'(m_valid), 32'd0);

        // Program ramp thresholds plus an out-of-range write that must be ignored.
        for (int i = 0; i < N_FEAT; i++) write_thr(4'(i), 8'(16 * i));
        write_thr(4'd12, 8'hFF);
        write_thr(4'd15, 8'hFF);
        foreach (tbl[k]) send_frame(tbl[k].smp, tbl[k].exp);
        wait_drain();
        check("frame_cnt_tbl", 32'(frame_cnt), 32'(exp_cnt));

        // Same-cycle write and compare on index 0: this beat uses the old 0x00.
        thr_we = 1'b1; thr_idx = 4'd0; thr_data = 8'hFF;
        push_exp(11'h001);
        send_beat(8'h00, 1'b0);
        thr_we = 1'b0;
        m_thr[0] = 8'hFF;
        for (int i = 1; i < N_FEAT; i++) send_beat(8'h00, i == N_FEAT - 1);
        send_frame({N_FEAT{8'h00}}, 11'h000);
        wait_drain();

        // Back-pressure: two frames with m_ready low.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < N_FEAT; i++) smp[i*W +: W] = (i % 2 == 0) ? 8'hFF : 8'h00;
        fa = model_feat(smp);
        check("model_alt", 32'(fa), 32'h555);
        send_frame(smp, fa);
        smp_b = ~smp;
        for (int i = 0; i < N_FEAT - 1; i++) send_beat(smp_b[i*W +: W], 1'b0);
        s_valid = 1'b1; s_data = smp_b[(N_FEAT-1)*W +: W]; s_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            check("stall_m_feat", 32'(m_feat), 32'(fa));
            check("stall_m_valid", 32'(m_valid), 32'd1);
        end
        push_exp(model_feat(smp_b));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("unstall_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_last = 1'b0;
        check("b2b_m_valid", 32'(m_valid), 32'd1);
        check("frame_cnt_2", 32'(frame_cnt), 32'd2);
        wait_drain();

        // Short frame: last on 5th beat.
        sh0 = n_short; lg0 = n_long;
        for (int i = 0; i < 5; i++) send_beat(8'hFF, i == 4);
        check("err_short_pulse", 32'(err_short), 32'd1);
        check("short_no_valid", 32'(m_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("err_short_count", 32'(n_short - sh0), 32'd1);
        send_frame(smp, fa);
        wait_drain();

        // Long frame: 14 beats, last on 14th.
        for (int i = 0; i < 14; i++) begin
            send_beat(8'hFF, i == 13);
            if (i == 10) check("err_long_pulse", 32'(err_long), 32'd1);
            check("long_no_valid", 32'(m_valid), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("err_long_count", 32'(n_long - lg0), 32'd1);
        check("err_short_none", 32'(n_short - sh0), 32'd1);
        send_frame(smp_b, model_feat(smp_b));
        wait_drain();
        check("frame_cnt_err", 32'(frame_cnt), 32'(exp_cnt));

        // Reset mid-frame at beat 6.
        for (int i = 0; i < 6; i++) send_beat(8'hFF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid_m_valid", 32'(m_valid), 32'd0);
        check("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(smp, 11'h555);
        wait_drain();
        check("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);

        // Reset while a vector is held.
        m_ready = 1'b0;
        send_frame(smp_b, 11'h2AA);
        check("held_m_valid", 32'(m_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_held_m_valid", 32'(m_valid), 32'd0);
        check("rst_held_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;

        // Randomised frames with random thresholds and m_ready back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    if ($urandom_range(0, 1) == 1)
                        write_thr(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                    for (int i = 0; i < N_FEAT; i++) smp[i*W +: W] = 8'($urandom_range(0, 255));
                    send_frame(smp, model_feat(smp));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join
        wait_drain();
        check("frame_cnt_rand", 32'(frame_cnt), 32'(exp_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
